// File: rtl/bin_to_bcd_pipe.sv
// rtl/bin_to_bcd_pipe.sv - sequential binary to packed BCD converter with valid/ready handshakes.
// Define BCD_SIGNED_EN to treat bin_in as two's complement and report the sign on bcd_sign.
module bin_to_bcd_pipe #(
    parameter int BIN_W = 13,
    parameter int DIG_N = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIN_W-1:0]     bin_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*DIG_N-1:0]   bcd_out,
    output logic                 bcd_ovf,
    output logic                 bcd_sign
);

    localparam int BCD_W  = 4 * DIG_N;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] v;
        v = 32'd1;
        for (int i = 0; i < n; i++) v = v * 32'd10;
        return v;
    endfunction

    localparam logic [31:0] MAX_VAL = pow10(DIG_N) - 32'd1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [WORK_W-1:0]   work_q, work_step;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;
    logic [BIN_W-1:0]    mag;
    logic                last_step;
    logic                capture;

`ifdef BCD_SIGNED_EN
    // Negation at BIN_W bits maps the most negative input onto its exact magnitude.
    assign mag = bin_in[BIN_W-1] ? (~bin_in + BIN_W'(1)) : bin_in;
`else
    assign mag = bin_in;
`endif

    assign last_step = (cnt_q == CNT_W'(BIN_W - 1));
    assign capture   = (state_q == IDLE) && in_valid;

    always_comb begin
        logic [WORK_W-1:0] tmp;
        tmp = work_q;
        for (int d = 0; d < DIG_N; d++) begin
            if (tmp[BIN_W+4*d +: 4] > 4'd4)
                tmp[BIN_W+4*d +: 4] = tmp[BIN_W+4*d +: 4] + 4'd3;
        end
        work_step = {tmp[WORK_W-2:0], 1'b0};
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                if (last_step) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            work_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            bcd_out <= '0;
            bcd_ovf <= 1'b0;
        end else if (capture) begin
            work_q <= {{BCD_W{1'b0}}, mag};
            cnt_q  <= '0;
            ovf_q  <= (32'(mag) > MAX_VAL);
        end else if (state_q == SHIFT) begin
            work_q <= work_step;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last_step) begin
                bcd_out <= ovf_q ? {DIG_N{4'h9}} : work_step[WORK_W-1 -: BCD_W];
                bcd_ovf <= ovf_q;
            end
        end
    end

`ifdef BCD_SIGNED_EN
    logic sign_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sign_q   <= 1'b0;
            bcd_sign <= 1'b0;
        end else if (capture) begin
            sign_q <= bin_in[BIN_W-1];
        end else if (state_q == SHIFT && last_step) begin
            bcd_sign <= sign_q;
        end
    end
`else
    assign bcd_sign = 1'b0;
`endif

endmodule
